ahb_bram_ctrl: RTL and testbench

AHB-Lite slave that owns the on-chip block RAM's write/read ports and drives them from the Cortex-M0 bus. It converts AHB address/data phases into word-indexed RAM addresses, per-byte write enables and write data. It returns read data with zero wait states, including store-to-load forwarding for back-to-back accesses. Misaligned or illegal-size transfers receive a two-cycle ERROR response.

---
 rtl/ahb_bram_ctrl.sv | 113 +++++++++++
 tb/tb_ahb_bram_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a single-clock block RAM: zero-wait-state reads and writes,
// store-to-load forwarding for back-to-back write/read, and a two-cycle ERROR response.
module ahb_bram_ctrl #(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic                  HWRITE,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] BRAM_WADDR,
   output logic [31:0]           BRAM_WDATA,
   output logic [3:0]            BRAM_WE,
   output logic [ADDR_WIDTH-1:0] BRAM_RADDR,
   input  logic [31:0]           BRAM_RDATA
);

   localparam logic [1:0] ST_OK   = 2'd0;
   localparam logic [1:0] ST_ERR1 = 2'd1;
   localparam logic [1:0] ST_ERR2 = 2'd2;

   logic                  acc;
   logic                  legal;
   logic                  rd_hit;
   logic [3:0]            be;
   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            state_reg;
   logic [1:0]            state_next;
   logic                  wr_pend_reg;
   logic [ADDR_WIDTH-1:0] idx_reg;
   logic [3:0]            be_reg;
   logic [3:0]            fwd_mask_reg;
   logic [31:0]           fwd_data_reg;
   logic                  addr_unused;

   assign acc = HSEL & HREADY & HTRANS[1];
   assign idx = HADDR[ADDR_WIDTH+1:2];
   assign addr_unused = &{1'b0, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

   always_comb begin
      legal = 1'b0;
      be    = 4'b0000;
      case (HSIZE)
         3'd0: begin
            legal = 1'b1;
            be    = 4'b0001 << HADDR[1:0];
         end
         3'd1: begin
            legal = ~HADDR[0];
            be    = HADDR[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: begin
            legal = (HADDR[1:0] == 2'b00);
            be    = 4'b1111;
         end
         default: ;
      endcase
   end

   // RAM is read-first, so a read issued while the previous write commits sees stale bytes
   assign rd_hit = acc & legal & ~HWRITE & wr_pend_reg & (idx == idx_reg);

   always_comb begin
      state_next = ST_OK;
      case (state_reg)
         ST_ERR1: state_next = ST_ERR2;
         default: state_next = (acc & ~legal) ? ST_ERR1 : ST_OK;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg    <= ST_OK;
         wr_pend_reg  <= 1'b0;
         idx_reg      <= '0;
         be_reg       <= 4'b0000;
         fwd_mask_reg <= 4'b0000;
         fwd_data_reg <= 32'h0;
      end else begin
         state_reg    <= state_next;
         wr_pend_reg  <= acc & legal & HWRITE;
         fwd_mask_reg <= rd_hit ? be_reg : 4'b0000;
         if (acc & legal) begin
            idx_reg <= idx;
            be_reg  <= be;
         end
         if (rd_hit)
            fwd_data_reg <= HWDATA;
      end
   end

   assign HREADYOUT  = (state_reg != ST_ERR1);
   assign HRESP      = (state_reg != ST_OK);
   assign BRAM_WE    = wr_pend_reg ? be_reg : 4'b0000;
   assign BRAM_WADDR = idx_reg;
   assign BRAM_WDATA = HWDATA;
   assign BRAM_RADDR = idx;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_merge
         assign HRDATA[8*gi +: 8] = fwd_mask_reg[gi] ? fwd_data_reg[8*gi +: 8]
                                                     : BRAM_RDATA[8*gi +: 8];
      end
   endgenerate

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Bench for ahb_bram_ctrl: behavioural RAM, transaction-level reference model checked every
// cycle, plus literal expectations from the directed scenarios.
module tb_ahb_bram_ctrl;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic [13:0] BRAM_WADDR;
   logic [31:0] BRAM_WDATA;
   logic [3:0]  BRAM_WE;
   logic [13:0] BRAM_RADDR;
   logic [31:0] BRAM_RDATA;

   logic        blk;
   logic        chk_on;
   logic        pre_en;
   logic [13:0] pre_idx;
   logic [31:0] pre_val;

   int tests = 0;
   int fails = 0;

   // reference model state
   logic [31:0] model_mem [0:16383];
   logic        m_wr;
   logic        m_rd;
   logic [13:0] m_idx;
   logic [3:0]  m_lanes;
   int          m_err;       // 0 okay, 2 first error cycle, 1 second error cycle

   logic [31:0] bram_mem [0:16383];

   always #5 HCLK = ~HCLK;

   assign HREADY = HREADYOUT & ~blk;

   ahb_bram_ctrl #(.ADDR_WIDTH(14)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .BRAM_WADDR(BRAM_WADDR), .BRAM_WDATA(BRAM_WDATA), .BRAM_WE(BRAM_WE),
      .BRAM_RADDR(BRAM_RADDR), .BRAM_RDATA(BRAM_RDATA)
   );

   // behavioural block RAM: registered read, read-first, byte enables
   always @(posedge HCLK) begin
      BRAM_RDATA <= bram_mem[BRAM_RADDR];
      if (pre_en)
         bram_mem[pre_idx] <= pre_val;
      else
         for (int b = 0; b < 4; b++)
            if (BRAM_WE[b]) bram_mem[BRAM_WADDR][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // bus-level model: an aligned transfer of 2^size bytes touches the lanes it covers
   task automatic model_edge();
      bit         acc, lg;
      int         nb;
      logic [7:0] lm;
      if (!HRESETn) begin
         m_wr = 0; m_rd = 0; m_err = 0;
         return;
      end
      if (m_wr)
         for (int b = 0; b < 4; b++)
            if (m_lanes[b]) model_mem[m_idx][8*b +: 8] = HWDATA[8*b +: 8];
      acc = HSEL && (m_err != 2) && !blk && HTRANS[1];
      lg  = 0;
      lm  = 8'h00;
      if (HSIZE <= 3'd2) begin
         nb = 1 << HSIZE;
         lg = ((HADDR % nb) == 0);
         lm = ((8'd1 << nb) - 8'd1) << HADDR[1:0];
      end
      if (acc)
         $display("[TB] t=%0t %s addr=%h size=%0d legal=%0d", $time,
                  HWRITE ? "write" : "read ", HADDR, HSIZE, lg);
      m_err = (m_err == 2) ? 1 : ((acc && !lg) ? 2 : 0);
      m_wr  = acc && lg && HWRITE;
      m_rd  = acc && lg && !HWRITE;
      if (acc && lg) begin
         m_idx   = HADDR[15:2];
         m_lanes = lm[3:0];
      end
   endtask

   always @(negedge HCLK) begin
      if (chk_on) begin
         chk("hreadyout", 32'(HREADYOUT), 32'(m_err != 2));
         chk("hresp", 32'(HRESP), 32'(m_err != 0));
         chk("bram_we", 32'(BRAM_WE), m_wr ? 32'(m_lanes) : 32'h0);
         chk("bram_raddr", 32'(BRAM_RADDR), 32'(HADDR[15:2]));
         if (m_wr) begin
            chk("bram_waddr", 32'(BRAM_WADDR), 32'(m_idx));
            chk("bram_wdata", BRAM_WDATA, HWDATA);
         end
         if (m_rd)
            chk("hrdata", HRDATA, model_mem[m_idx]);
      end
   end

   task automatic tick();
      @(posedge HCLK);
      model_edge();
      #1;
   endtask

   task automatic drv(input logic s, input logic [1:0] t, input logic [31:0] a,
                      input logic [2:0] z, input logic w, input logic [31:0] d, input logic b);
      HSEL = s; HTRANS = t; HADDR = a; HSIZE = z; HWRITE = w; HWDATA = d; blk = b;
      #3;
   endtask

   task automatic idle(input logic [31:0] d);
      drv(1'b0, 2'b00, 32'h0, 3'd0, 1'b0, d, 1'b0);
   endtask

   task automatic preset(input logic [31:0] a, input logic [31:0] v);
      pre_en = 1'b1; pre_idx = a[15:2]; pre_val = v;
      model_mem[a[15:2]] = v;
      tick();
      pre_en = 1'b0;
   endtask

   initial begin
      HRESETn = 1'b0; chk_on = 1'b0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      m_wr = 0; m_rd = 0; m_err = 0; m_idx = '0; m_lanes = '0;
      idle(32'h0);
      tick();
      preset(32'h2000, 32'hAABBCCDD);
      preset(32'h3000, 32'hCAFEF00D);
      preset(32'h4000, 32'h0BADC0DE);
      preset(32'h5000, 32'h5A5A5A5A);
      chk("reset_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("reset_hresp", 32'(HRESP), 32'h0);
      chk("reset_we", 32'(BRAM_WE), 32'h0);
      chk_on = 1'b1;
      HRESETn = 1'b1;
      tick();

      // word write then read
      drv(1, 2'b10, 32'h1000, 3'd2, 1, 32'h0, 0); tick();
      idle(32'hDEADBEEF);
      chk("t1_we", 32'(BRAM_WE), 32'hF);
      chk("t1_waddr", 32'(BRAM_WADDR), 32'h400);
      tick();
      drv(1, 2'b10, 32'h1000, 3'd2, 0, 32'h0, 0); tick();
      idle(32'h0);
      chk("t1_rdata", HRDATA, 32'hDEADBEEF);
      chk("t1_hresp", 32'(HRESP), 32'h0);
      tick();

      // byte and half writes into a preset word, read forwarded from the half write
      drv(1, 2'b10, 32'h2001, 3'd0, 1, 32'h0, 0); tick();
      drv(1, 2'b10, 32'h2002, 3'd1, 1, 32'h0000_1200, 0);
      chk("t2_we_byte", 32'(BRAM_WE), 32'h2);
      tick();
      drv(1, 2'b10, 32'h2000, 3'd2, 0, 32'h5566_0000, 0);
      chk("t2_we_half", 32'(BRAM_WE), 32'hC);
      tick();
      idle(32'h0);
      chk("t2_rdata", HRDATA, 32'h556612DD);
      tick();

      // write immediately followed by a read of the same word
      drv(1, 2'b10, 32'h0, 3'd2, 1, 32'h0, 0); tick();
      drv(1, 2'b10, 32'h0, 3'd2, 0, 32'h11223344, 0); tick();
      drv(1, 2'b10, 32'h3, 3'd0, 1, 32'h0, 0);
      chk("t3_fwd_word", HRDATA, 32'h11223344);
      tick();
      drv(1, 2'b10, 32'h0, 3'd2, 0, 32'h9900_0000, 0); tick();
      idle(32'h0);
      chk("t3_fwd_byte", HRDATA, 32'h99223344);
      tick();

      // illegal transfers
      drv(1, 2'b10, 32'h3002, 3'd2, 0, 32'h0, 0); tick();
      idle(32'h0);
      chk("t4_err1_ready", 32'(HREADYOUT), 32'h0);
      chk("t4_err1_resp", 32'(HRESP), 32'h1);
      tick();
      idle(32'h0);
      chk("t4_err2_ready", 32'(HREADYOUT), 32'h1);
      chk("t4_err2_resp", 32'(HRESP), 32'h1);
      tick();
      drv(1, 2'b10, 32'h3001, 3'd1, 1, 32'h0, 0); tick();
      idle(32'hFFFFFFFF);
      chk("t4_wr_err_ready", 32'(HREADYOUT), 32'h0);
      chk("t4_wr_err_we", 32'(BRAM_WE), 32'h0);
      tick();
      drv(1, 2'b10, 32'h3000, 3'd3, 0, 32'h0, 0);
      chk("t4_err2b_resp", 32'(HRESP), 32'h1);
      tick();
      idle(32'h0);
      chk("t4_size3_ready", 32'(HREADYOUT), 32'h0);
      tick();
      drv(1, 2'b10, 32'h3000, 3'd2, 0, 32'h0, 0); tick();
      idle(32'h0);
      chk("t4_mem_intact", HRDATA, 32'hCAFEF00D);
      chk("t4_resp_ok", 32'(HRESP), 32'h0);
      tick();

      // reset during a write data phase
      drv(1, 2'b10, 32'h4000, 3'd2, 1, 32'h0, 0); tick();
      HSEL = 0; HTRANS = 2'b00; HWDATA = 32'h12345678;
      #1;
      HRESETn = 1'b0;
      m_wr = 0; m_rd = 0; m_err = 0;
      #1;
      chk("t5_we_async", 32'(BRAM_WE), 32'h0);
      chk("t5_ready", 32'(HREADYOUT), 32'h1);
      chk("t5_resp", 32'(HRESP), 32'h0);
      tick();
      HRESETn = 1'b1;
      drv(1, 2'b10, 32'h4000, 3'd2, 0, 32'h0, 0); tick();
      idle(32'h0);
      chk("t5_mem_intact", HRDATA, 32'h0BADC0DE);
      tick();

      // transfers that must not be accepted
      for (int v = 0; v < 4; v++) begin
         case (v)
            0: drv(1, 2'b00, 32'h5000, 3'd2, 1, 32'h0, 0);
            1: drv(1, 2'b01, 32'h5000, 3'd2, 1, 32'h0, 0);
            2: drv(0, 2'b10, 32'h5000, 3'd2, 1, 32'h0, 0);
            default: drv(1, 2'b10, 32'h5000, 3'd2, 1, 32'h0, 1);
         endcase
         tick();
         idle(32'hFFFFFFFF);
         chk("t6_no_we", 32'(BRAM_WE), 32'h0);
         chk("t6_ready", 32'(HREADYOUT), 32'h1);
         tick();
      end
      drv(1, 2'b10, 32'h5000, 3'd2, 0, 32'h0, 0); tick();
      idle(32'h0);
      chk("t6_mem_intact", HRDATA, 32'h5A5A5A5A);
      tick();

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
